// File: rtl/systolic_feeder.sv
// Input skew stage for the 2-row Givens QR systolic array.
// Accepts one 4-word row per cycle over valid/ready. Lane j (0-based) is
// delayed j*SKEW cycles behind lane 0, which gives the array its diagonal
// wavefront. After the last row of a matrix, the feeder shifts in zero rows
// until lane 3 has drained. It also raises a start pulse with the first word
// and a done pulse with the last word.
module systolic_feeder #(
   parameter int W    = 32,
   parameter int ROWS = 4,
   parameter int SKEW = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_row0,
   input  logic [W-1:0] in_row1,
   input  logic [W-1:0] in_row2,
   input  logic [W-1:0] in_row3,
   output logic         start,
   output logic [W-1:0] x01,
   output logic [W-1:0] x02,
   output logic [W-1:0] x03,
   output logic [W-1:0] x04,
   output logic         busy,
   output logic         done
);

   localparam int RCW = $clog2(ROWS + 1);
   localparam int DCW = $clog2(3 * SKEW + 1);

   localparam logic [RCW-1:0] ROW_LAST  = RCW'(ROWS - 1);
   localparam logic [DCW-1:0] DRAIN_PRE = DCW'(3 * SKEW - 1);
   localparam logic [DCW-1:0] DRAIN_MAX = DCW'(3 * SKEW);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FEED  = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic [RCW-1:0]  r_row_cnt;
   logic [DCW-1:0]  r_drain_cnt;
   logic            r_start;
   logic            r_done;
   logic            r_busy;
   logic            w_accept;
   logic            w_idle_entry;
   logic [W-1:0]    w_in   [4];
   logic [W-1:0]    w_tail [4];

   // A row enters only in IDLE or FEED. Reset blocks entry in the same cycle.
   assign in_ready     = !rst && (r_state != S_DRAIN);
   assign w_accept     = in_valid && in_ready;
   assign w_idle_entry = (r_state != S_IDLE) && (w_next == S_IDLE);

   assign w_in[0] = in_row0;
   assign w_in[1] = in_row1;
   assign w_in[2] = in_row2;
   assign w_in[3] = in_row3;

   // Per-lane shift lines. Lane j holds 1 + j*SKEW words. The head register
   // takes the accepted word, or zero when no row is accepted (a bubble or a
   // drain cycle), so the array sees a Givens identity in that slot.
   for (genvar j = 0; j < 4; j++) begin : g_lane
      localparam int LEN = 1 + j * SKEW;

      logic [W-1:0] r_sr [LEN];
      logic [W-1:0] w_head;

      assign w_head = w_accept ? w_in[j] : '0;

      // Shift the lane by one stage every cycle.
      always_ff @(posedge clk) begin
         if (rst) begin
            // NOTE: these are discrete flops on the array's input path, not a RAM.
            // They must be reset so that no stale word reaches the array after rst.
            for (int i = 0; i < LEN; i++) r_sr[i] <= '0;
         end else begin
            r_sr[0] <= w_head;
            for (int i = 1; i < LEN; i++) r_sr[i] <= r_sr[i-1];
         end
      end

      assign w_tail[j] = r_sr[LEN-1];
   end

   assign x01   = w_tail[0];
   assign x02   = w_tail[1];
   assign x03   = w_tail[2];
   assign x04   = w_tail[3];
   assign start = r_start;
   assign done  = r_done;
   assign busy  = r_busy;

   // Next-state logic: leave IDLE on the first accept. Leave FEED on the accept
   // that completes the matrix. Leave DRAIN on the edge that ends the done cycle.
   always_comb begin
      // NOTE: the default assignment comes first, so every path assigns w_next and no latch is inferred.
      w_next = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (w_accept) w_next = (ROWS == 1) ? S_DRAIN : S_FEED;
         end
         S_FEED: begin
            if (w_accept && (r_row_cnt == ROW_LAST)) w_next = S_DRAIN;
         end
         S_DRAIN: begin
            if (r_done) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // State, counters and registered control pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_row_cnt   <= '0;
         r_drain_cnt <= '0;
         r_start     <= 1'b0;
         r_done      <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments. Every register here samples the pre-edge values of the others.
         r_state <= w_next;
         r_start <= (r_state == S_IDLE) && w_accept;
         // The drain counter reads 3*SKEW-1 in the cycle before lane 3 shows the last word.
         r_done  <= (r_state == S_DRAIN) && (r_drain_cnt == DRAIN_PRE);
         r_busy  <= (w_next != S_IDLE);

         if (w_idle_entry) begin
            r_row_cnt <= '0;
         end else if (w_accept) begin
            r_row_cnt <= (r_state == S_IDLE) ? RCW'(1) : r_row_cnt + RCW'(1);
         end

         if (w_idle_entry) begin
            r_drain_cnt <= '0;
         end else if ((r_state == S_DRAIN) && (r_drain_cnt != DRAIN_MAX)) begin
            r_drain_cnt <= r_drain_cnt + DCW'(1);
         end
      end
   end

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder. It instantiates two copies: dut_a with
// ROWS=4 and SKEW=1, and dut_b with ROWS=1 and SKEW=2. Cycle k is the interval
// after clock edge k-1. A row driven in cycle c is accepted at edge c and
// appears on lane j in cycle c+1+j*SKEW.
module tb_systolic_feeder;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst;

   logic         a_valid;
   logic         a_ready;
   logic [W-1:0] a_row [4];
   logic         a_start;
   logic         a_busy;
   logic         a_done;
   logic [W-1:0] a_x   [4];

   logic         b_valid;
   logic         b_ready;
   logic [W-1:0] b_row [4];
   logic         b_start;
   logic         b_busy;
   logic         b_done;
   logic [W-1:0] b_x   [4];

   int n_cmp = 0;
   int n_err = 0;

   // Rows the bench expects to be accepted at the end of cycle c (zero = none).
   logic [W-1:0] head [0:31][0:3];

   always #5 clk = ~clk;

   systolic_feeder #(.W(W), .ROWS(4), .SKEW(1)) dut_a (
      .clk(clk), .rst(rst), .in_valid(a_valid), .in_ready(a_ready),
      .in_row0(a_row[0]), .in_row1(a_row[1]), .in_row2(a_row[2]), .in_row3(a_row[3]),
      .start(a_start), .x01(a_x[0]), .x02(a_x[1]), .x03(a_x[2]), .x04(a_x[3]),
      .busy(a_busy), .done(a_done)
   );

   systolic_feeder #(.W(W), .ROWS(1), .SKEW(2)) dut_b (
      .clk(clk), .rst(rst), .in_valid(b_valid), .in_ready(b_ready),
      .in_row0(b_row[0]), .in_row1(b_row[1]), .in_row2(b_row[2]), .in_row3(b_row[3]),
      .start(b_start), .x01(b_x[0]), .x02(b_x[1]), .x03(b_x[2]), .x04(b_x[3]),
      .busy(b_busy), .done(b_done)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_head;
      for (int c = 0; c < 32; c++)
         for (int j = 0; j < 4; j++) head[c][j] = '0;
   endtask

   // Expected word on lane j in cycle c, given the per-lane step s.
   function automatic logic [W-1:0] exp_lane(input int c, input int j, input int s);
      int src;
      src = c - 1 - j * s;
      if (src < 0 || src > 31) return '0;
      return head[src][j];
   endfunction

   task automatic test_reset;
      rst     = 1'b1;
      a_valid = 1'b1;
      b_valid = 1'b1;
      for (int j = 0; j < 4; j++) begin
         a_row[j] = W'(32'h55 + j);
         b_row[j] = W'(32'h66 + j);
      end
      for (int k = 0; k < 2; k++) begin
         tick;
         n_cmp++;
         if ({a_ready, a_start, a_busy, a_done} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_ctl cycle %0d: got rdy/start/busy/done=%b want 0000",
                     k, {a_ready, a_start, a_busy, a_done});
         end
         n_cmp++;
         if ((a_x[0] | a_x[1] | a_x[2] | a_x[3]) !== '0) begin
            n_err++;
            $display("FAIL reset_lanes cycle %0d: got %h %h %h %h want all 0",
                     k, a_x[0], a_x[1], a_x[2], a_x[3]);
         end
         n_cmp++;
         if ({b_ready, b_start, b_busy, b_done} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_ctl_b cycle %0d: got %b want 0000",
                     k, {b_ready, b_start, b_busy, b_done});
         end
      end
      rst     = 1'b0;
      a_valid = 1'b0;
      b_valid = 1'b0;
      #1;
      n_cmp++;
      if (a_ready !== 1'b1) begin
         n_err++;
         $display("FAIL reset_release_ready: got %b want 1", a_ready);
      end
      tick;
   endtask

   task automatic test_back_to_back(input string tag);
      logic [3:0] exp_ctl;
      clear_head;
      for (int c = 0; c < 10; c++) begin
         if (c < 4) begin
            a_valid = 1'b1;
            for (int j = 0; j < 4; j++) begin
               a_row[j]   = W'(4 * c + j + 1);
               head[c][j] = a_row[j];
            end
         end else begin
            a_valid = 1'b0;
            for (int j = 0; j < 4; j++) a_row[j] = W'(32'hBAD0_0000 + 16 * c + j);
         end
         #1;
         exp_ctl = {c == 1, c == 7, (c >= 1 && c <= 7), !(c >= 4 && c <= 7)};
         n_cmp++;
         if ({a_start, a_done, a_busy, a_ready} !== exp_ctl) begin
            n_err++;
            $display("FAIL %s_ctl cycle %0d: got start/done/busy/rdy=%b want %b",
                     tag, c, {a_start, a_done, a_busy, a_ready}, exp_ctl);
         end
         for (int j = 0; j < 4; j++) begin
            n_cmp++;
            if (a_x[j] !== exp_lane(c, j, 1)) begin
               n_err++;
               $display("FAIL %s_lane%0d cycle %0d: got %0d want %0d",
                        tag, j + 1, c, a_x[j], exp_lane(c, j, 1));
            end
         end
         if (c == 5) begin
            n_cmp++;
            if ({a_x[0], a_x[1], a_x[2], a_x[3]} !== {32'd0, 32'd14, 32'd11, 32'd8}) begin
               n_err++;
               $display("FAIL %s_diag cycle 5: got %0d %0d %0d %0d want 0 14 11 8",
                        tag, a_x[0], a_x[1], a_x[2], a_x[3]);
            end
         end
         if (c == 7) begin
            n_cmp++;
            if (a_x[3] !== 32'd16) begin
               n_err++;
               $display("FAIL %s_last_word cycle 7: got %0d want 16", tag, a_x[3]);
            end
         end
         tick;
      end
   endtask

   // Row order: r0, r1, bubble, r2, r3. The bubble cycle drives junk with valid low.
   task automatic test_bubble;
      logic [3:0] exp_ctl;
      int         k;
      clear_head;
      for (int c = 0; c < 12; c++) begin
         k = (c < 2) ? c : ((c == 3 || c == 4) ? c - 1 : -1);
         if (k >= 0) begin
            a_valid = 1'b1;
            for (int j = 0; j < 4; j++) begin
               a_row[j]   = W'(16 * (k + 1) + j);
               head[c][j] = a_row[j];
            end
         end else begin
            a_valid = 1'b0;
            for (int j = 0; j < 4; j++) a_row[j] = W'(32'hDEAD_0000 + j);
         end
         #1;
         exp_ctl = {c == 1, c == 8, (c >= 1 && c <= 8), !(c >= 5 && c <= 8)};
         n_cmp++;
         if ({a_start, a_done, a_busy, a_ready} !== exp_ctl) begin
            n_err++;
            $display("FAIL bubble_ctl cycle %0d: got start/done/busy/rdy=%b want %b",
                     c, {a_start, a_done, a_busy, a_ready}, exp_ctl);
         end
         for (int j = 0; j < 4; j++) begin
            n_cmp++;
            if (a_x[j] !== exp_lane(c, j, 1)) begin
               n_err++;
               $display("FAIL bubble_lane%0d cycle %0d: got %0d want %0d",
                        j + 1, c, a_x[j], exp_lane(c, j, 1));
            end
         end
         if (c >= 3 && c <= 6) begin
            n_cmp++;
            if (a_x[c-3] !== '0) begin
               n_err++;
               $display("FAIL bubble_slot lane%0d cycle %0d: got %h want 0", c - 2, c, a_x[c-3]);
            end
         end
         tick;
      end
   endtask

   task automatic test_skew2;
      logic [3:0] exp_ctl;
      logic [W-1:0] word [4];
      word[0] = 32'hA000_000A;
      word[1] = 32'hB000_000B;
      word[2] = 32'hC000_000C;
      word[3] = 32'hD000_000D;
      clear_head;
      for (int c = 0; c < 10; c++) begin
         if (c == 0) begin
            b_valid = 1'b1;
            for (int j = 0; j < 4; j++) begin
               b_row[j]   = word[j];
               head[0][j] = word[j];
            end
         end else begin
            b_valid = 1'b0;
            for (int j = 0; j < 4; j++) b_row[j] = W'(32'hF00D_0000 + j);
         end
         #1;
         exp_ctl = {c == 1, c == 7, (c >= 1 && c <= 7), !(c >= 1 && c <= 7)};
         n_cmp++;
         if ({b_start, b_done, b_busy, b_ready} !== exp_ctl) begin
            n_err++;
            $display("FAIL skew2_ctl cycle %0d: got start/done/busy/rdy=%b want %b",
                     c, {b_start, b_done, b_busy, b_ready}, exp_ctl);
         end
         for (int j = 0; j < 4; j++) begin
            n_cmp++;
            if (b_x[j] !== exp_lane(c, j, 2)) begin
               n_err++;
               $display("FAIL skew2_lane%0d cycle %0d: got %h want %h",
                        j + 1, c, b_x[j], exp_lane(c, j, 2));
            end
            if (c == 1 + 2 * j) begin
               n_cmp++;
               if (b_x[j] !== word[j]) begin
                  n_err++;
                  $display("FAIL skew2_slot lane%0d cycle %0d: got %h want %h",
                           j + 1, c, b_x[j], word[j]);
               end
            end
         end
         tick;
      end
   endtask

   task automatic test_reset_mid;
      for (int c = 0; c < 2; c++) begin
         a_valid = 1'b1;
         for (int j = 0; j < 4; j++) a_row[j] = W'(32'h700 + 4 * c + j + 1);
         tick;
      end
      // Cycle 2: row 1 is in flight on lane 1, and reset is asserted.
      rst     = 1'b1;
      a_valid = 1'b1;
      for (int j = 0; j < 4; j++) a_row[j] = W'(32'h709 + j);
      #1;
      n_cmp++;
      if (a_x[0] !== W'(32'h705)) begin
         n_err++;
         $display("FAIL rmid_inflight: got %h want 705", a_x[0]);
      end
      n_cmp++;
      if (a_ready !== 1'b0) begin
         n_err++;
         $display("FAIL rmid_ready_in_rst: got %b want 0", a_ready);
      end
      tick;
      rst     = 1'b0;
      a_valid = 1'b0;
      #1;
      n_cmp++;
      if ({a_start, a_done, a_busy, a_ready} !== 4'b0001) begin
         n_err++;
         $display("FAIL rmid_ctl_after: got start/done/busy/rdy=%b want 0001",
                  {a_start, a_done, a_busy, a_ready});
      end
      n_cmp++;
      if ((a_x[0] | a_x[1] | a_x[2] | a_x[3]) !== '0) begin
         n_err++;
         $display("FAIL rmid_lanes_after: got %h %h %h %h want all 0",
                  a_x[0], a_x[1], a_x[2], a_x[3]);
      end
      tick;
      for (int c = 0; c < 8; c++) begin
         #1;
         n_cmp++;
         if ({a_done, a_busy, (a_x[0] | a_x[1] | a_x[2] | a_x[3]) != '0} !== 3'b000) begin
            n_err++;
            $display("FAIL rmid_quiet cycle %0d: got done=%b busy=%b lanes=%h %h %h %h want all 0",
                     c, a_done, a_busy, a_x[0], a_x[1], a_x[2], a_x[3]);
         end
         tick;
      end
      test_back_to_back("rmid_rerun");
   endtask

   // A producer holds valid high and advances to its next row on each handshake.
   task automatic test_continuous;
      logic [W-1:0] sent [0:15][0:3];
      logic [W-1:0] got  [0:3][0:15];
      int           got_n [4];
      int           n;
      logic         exp_ready;
      n = 0;
      for (int j = 0; j < 4; j++) got_n[j] = 0;
      for (int c = 0; c < 18; c++) begin
         a_valid = (c < 16);
         for (int j = 0; j < 4; j++) a_row[j] = W'(256 * (n + 1) + j + 1);
         #1;
         exp_ready = !((c >= 4 && c <= 7) || (c >= 12 && c <= 15));
         n_cmp++;
         if (a_ready !== exp_ready) begin
            n_err++;
            $display("FAIL cont_ready cycle %0d: got %b want %b", c, a_ready, exp_ready);
         end
         n_cmp++;
         if ({a_start, a_done} !== {(c == 1 || c == 9), (c == 7 || c == 15)}) begin
            n_err++;
            $display("FAIL cont_pulses cycle %0d: got start/done=%b%b want %b%b",
                     c, a_start, a_done, (c == 1 || c == 9), (c == 7 || c == 15));
         end
         for (int j = 0; j < 4; j++) begin
            if (a_x[j] != '0) begin
               if (got_n[j] < 16) got[j][got_n[j]] = a_x[j];
               got_n[j]++;
            end
         end
         if (a_valid && a_ready && n < 16) begin
            for (int j = 0; j < 4; j++) sent[n][j] = a_row[j];
            n++;
         end
         tick;
      end
      n_cmp++;
      if (n !== 8) begin
         n_err++;
         $display("FAIL cont_rows_accepted: got %0d want 8", n);
      end
      for (int j = 0; j < 4; j++) begin
         n_cmp++;
         if (got_n[j] !== 8) begin
            n_err++;
            $display("FAIL cont_lane%0d_count: got %0d want 8", j + 1, got_n[j]);
         end
         for (int i = 0; i < 8; i++) begin
            if (i < n && i < got_n[j]) begin
               n_cmp++;
               if (got[j][i] !== sent[i][j]) begin
                  n_err++;
                  $display("FAIL cont_lane%0d_word%0d: got %h want %h",
                           j + 1, i, got[j][i], sent[i][j]);
               end
            end
         end
      end
   endtask

   initial begin
      rst     = 1'b1;
      a_valid = 1'b0;
      b_valid = 1'b0;
      for (int j = 0; j < 4; j++) begin
         a_row[j] = '0;
         b_row[j] = '0;
      end
      test_reset;
      test_back_to_back("b2b");
      test_bubble;
      test_skew2;
      test_reset_mid;
      test_continuous;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule
